// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the shared-memory MIPS multicycle datapath: sequences one
// instruction at a time, stalls on mem_ready and counts retired instructions.
module mips_multicycle_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        instr_retired,
    output logic        illegal_op,
    output logic [31:0] retired_count
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEX   = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       pc_write;
    logic       branch;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_write_c;
    logic       retire_c;
    logic       illegal_c;

    // Returns {legal, alu_control}; unsupported funct codes fall back to add.
    function automatic logic [3:0] alu_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: alu_decode = {1'b1, ALU_ADD};
            6'b100010: alu_decode = {1'b1, ALU_SUB};
            6'b100100: alu_decode = {1'b1, ALU_AND};
            6'b100101: alu_decode = {1'b1, ALU_OR};
            6'b101010: alu_decode = {1'b1, ALU_SLT};
            default:   alu_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    always_comb begin
        state_d     = FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_src      = 2'b00;
        retire_c    = 1'b0;
        illegal_c   = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // Branch target is computed here so BRANCH can use ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
                retire_c    = mem_ready;
                state_d     = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = alu_decode(funct)[2:0];
                if (alu_decode(funct)[3]) begin
                    state_d = ALUWB;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write strobes and pulses are masked directly by reset so nothing
    // leaks out while reset is held, even though FETCH decodes mem_ready.
    assign pc_en         = (pc_write | (branch & zero)) & reset;
    assign ir_write      = ir_write_c & reset;
    assign reg_write     = reg_write_c & reset;
    assign mem_write     = mem_write_c & reset;
    assign instr_retired = retire_c & reset;
    assign illegal_op    = illegal_c & reset;
    assign state         = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            retired_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table of instructions with expected traces,
// checked through a scoreboard queue, plus reset corner-case sequences.
module tb_mips_multicycle_ctrl;

    logic        clock;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic        instr_retired;
    logic        illegal_op;
    logic [31:0] retired_count;

    mips_multicycle_ctrl dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
        .state(state), .instr_retired(instr_retired), .illegal_op(illegal_op),
        .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  fst;
        logic [3:0]  mst;
        logic        nz;
        logic [5:0]  cyc;
        logic [31:0] trace;
        logic [1:0]  ret;
        logic [1:0]  ill;
        logic [1:0]  rw;
        logic [1:0]  mtr;
        logic [1:0]  rdw;
        logic [1:0]  pcen;
        logic [3:0]  mw;
        logic        has_exec;
        logic [2:0]  alu;
        logic [1:0]  pcsrc;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] exp_count = 32'd0;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, id, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic [3:0] fst, input logic [3:0] mst, input logic nz,
                                input logic [5:0] cyc, input logic [31:0] trace,
                                input logic [1:0] ret, input logic [1:0] ill, input logic [1:0] rw,
                                input logic [1:0] mtr, input logic [1:0] rdw, input logic [1:0] pcen,
                                input logic [3:0] mw, input logic has_exec, input logic [2:0] alu,
                                input logic [1:0] pcsrc);
        vec_t v;
        v = '{op, fn, z, fst, mst, nz, cyc, trace, ret, ill, rw, mtr, rdw, pcen, mw, has_exec, alu, pcsrc};
        return v;
    endfunction

    // Runs one instruction from FETCH back to FETCH; called at posedge+1 in FETCH.
    task automatic run_instr(input int id, input vec_t v);
        vec_t e;
        int cyc = 0, ret = 0, ill = 0, rw = 0, mtr = 0, rdw = 0, pcen = 0, mw = 0, irw = 0;
        int fs, ms;
        logic [31:0] trace = 32'd0;
        logic [2:0]  alu_obs = 3'b000;
        logic [1:0]  pcsrc_obs = 2'b00;
        logic [31:0] cnt_before;
        logic        left = 1'b0;
        fs = int'(v.fst);
        ms = int'(v.mst);
        sb_q.push_back(v);
        opcode = v.op;
        funct  = v.fn;
        zero   = v.z;
        cnt_before = retired_count;
        do begin
            if (state == 4'd0) begin
                mem_ready = (fs == 0);
                if (fs > 0) fs--;
            end else if (state == 4'd3 || state == 4'd5) begin
                mem_ready = (ms == 0);
                if (ms > 0) ms--;
            end else begin
                mem_ready = ~v.nz;
            end
            @(negedge clock);
            trace = {trace[27:0], state};
            cyc++;
            if (state != 4'd0) left = 1'b1;
            if (ir_write) irw++;
            if (pc_en) pcen++;
            if (pc_en && state != 4'd0) pcsrc_obs = pc_src;
            if (reg_write) rw++;
            if (reg_write && mem_to_reg) mtr++;
            if (reg_write && reg_dst) rdw++;
            if (mem_write) mw++;
            if (instr_retired) ret++;
            if (illegal_op) ill++;
            if (state == 4'd6) alu_obs = alu_control;
            @(posedge clock);
            #1;
        end while (!(left && state == 4'd0) && cyc < 30);
        mem_ready = 1'b1;
        e = sb_q.pop_front();
        exp_count = exp_count + 32'(e.ret);
        chk("trace", id, trace, e.trace);
        chk("cycles", id, cyc, e.cyc);
        chk("retire", id, ret, e.ret);
        chk("illegal", id, ill, e.ill);
        chk("reg_write", id, rw, e.rw);
        chk("mem_to_reg_wb", id, mtr, e.mtr);
        chk("reg_dst_wb", id, rdw, e.rdw);
        chk("pc_en", id, pcen, e.pcen);
        chk("mem_write", id, mw, e.mw);
        chk("ir_write", id, irw, 1);
        chk("count_delta", id, retired_count - cnt_before, e.ret);
        if (e.has_exec) chk("alu_control", id, alu_obs, e.alu);
        if (e.pcen > 2'd1) chk("pc_src", id, pcsrc_obs, e.pcsrc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //              op       fn       z  fst mst nz cyc trace         ret ill rw mtr rdw pcen mw ex alu     pcsrc
        vecs[0]  = mk(6'h23, 6'h00, 0, 0, 0, 0, 5, 32'h00001234, 1, 0, 1, 1, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[1]  = mk(6'h2B, 6'h00, 0, 0, 3, 0, 7, 32'h00125555, 1, 0, 0, 0, 0, 1, 4, 0, 3'b010, 2'b00);
        vecs[2]  = mk(6'h04, 6'h00, 1, 0, 0, 0, 3, 32'h00000018, 1, 0, 0, 0, 0, 2, 0, 0, 3'b010, 2'b01);
        vecs[3]  = mk(6'h04, 6'h00, 0, 0, 0, 0, 3, 32'h00000018, 1, 0, 0, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[4]  = mk(6'h00, 6'h20, 0, 0, 0, 0, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b010, 2'b00);
        vecs[5]  = mk(6'h00, 6'h22, 0, 0, 0, 0, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b110, 2'b00);
        vecs[6]  = mk(6'h00, 6'h24, 0, 0, 0, 0, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b000, 2'b00);
        vecs[7]  = mk(6'h00, 6'h25, 0, 0, 0, 0, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b001, 2'b00);
        vecs[8]  = mk(6'h00, 6'h2A, 0, 0, 0, 0, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b111, 2'b00);
        vecs[9]  = mk(6'h08, 6'h00, 0, 0, 0, 0, 4, 32'h0000019A, 1, 0, 1, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[10] = mk(6'h02, 6'h00, 0, 0, 0, 0, 3, 32'h0000001B, 1, 0, 0, 0, 0, 2, 0, 0, 3'b010, 2'b10);
        vecs[11] = mk(6'h3F, 6'h00, 0, 0, 0, 0, 2, 32'h00000001, 0, 1, 0, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[12] = mk(6'h00, 6'h07, 0, 0, 0, 0, 3, 32'h00000016, 0, 1, 0, 0, 0, 1, 0, 1, 3'b010, 2'b00);
        vecs[13] = mk(6'h23, 6'h00, 0, 2, 1, 0, 8, 32'h00012334, 1, 0, 1, 1, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[14] = mk(6'h08, 6'h00, 0, 0, 0, 1, 4, 32'h0000019A, 1, 0, 1, 0, 0, 1, 0, 0, 3'b010, 2'b00);
        vecs[15] = mk(6'h00, 6'h22, 1, 0, 0, 1, 4, 32'h00000167, 1, 0, 1, 0, 1, 1, 0, 1, 3'b110, 2'b00);

        reset = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_state", 0, state, 4'd0);
        chk("rst_count", 0, retired_count, 32'd0);
        chk("rst_ir_write", 0, ir_write, 1'b0);
        chk("rst_pc_en", 0, pc_en, 1'b0);
        mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_state", 0, state, 4'd0);

        for (int i = 0; i < 16; i++) run_instr(i, vecs[i]);
        chk("count_total", 0, retired_count, exp_count);

        // Abandon a stalled store by asserting reset inside MEMWRITE.
        opcode = 6'h2B;
        for (int i = 0; i < 10 && state != 4'd5; i++) begin
            mem_ready = 1'b1;
            @(posedge clock);
            #1;
        end
        mem_ready = 1'b0;
        #1;
        chk("mw_state", 1, state, 4'd5);
        chk("mw_strobe", 1, mem_write, 1'b1);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("mid_rst_state", 1, state, 4'd0);
        chk("mid_rst_mem_write", 1, mem_write, 1'b0);
        chk("mid_rst_count", 1, retired_count, 32'd0);
        chk("mid_rst_retire", 1, instr_retired, 1'b0);
        chk("mid_rst_ir_write", 1, ir_write, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("held_rst_state", 1, state, 4'd0);
        reset = 1'b1;
        #1;
        chk("rel_ir_write", 1, ir_write, 1'b1);
        @(posedge clock);
        #1;
        chk("rel_decode", 1, state, 4'd1);
        chk("rel_count", 1, retired_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
